// File: rtl/vga_fb_arbiter.sv
// Framebuffer SRAM arbiter: display scanout has absolute priority, host uses idle slots.
// Define VGA_FB_ARB_HOST_READ_EN to enable host reads; otherwise every host transfer is a write.
module vga_fb_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_data_valid,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              disp_oob,
  output logic [15:0]       host_wait_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISP    = 2'd1,
    HOST_WR = 2'd2
`ifdef VGA_FB_ARB_HOST_READ_EN
   ,HOST_RD = 2'd3
`endif
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1
`ifdef VGA_FB_ARB_HOST_READ_EN
   ,TAG_HOST = 2'd2
`endif
  } tag_t;

  state_t            state, nxt;
  tag_t              tag_now, tag_q;
  logic              in_range, disp_hit;
  logic [ADDR_W-1:0] disp_addr;

  assign in_range   = (int'(disp_x) < H_RES) && (int'(disp_y) < V_RES);
  assign disp_hit   = disp_req & in_range;
  assign host_ready = host_valid & ~disp_req & ~reset;

  generate
    if (H_RES == 640) begin : g_shift
      assign disp_addr = (ADDR_W'(disp_y) << 9) + (ADDR_W'(disp_y) << 7) + ADDR_W'(disp_x);
    end else begin : g_mul
      assign disp_addr = ADDR_W'(disp_y) * ADDR_W'(H_RES) + ADDR_W'(disp_x);
    end
  endgenerate

`ifndef VGA_FB_ARB_HOST_READ_EN
  logic unused_host_we;
  assign unused_host_we = host_we;
`endif

  always_comb begin
    nxt = IDLE;
    if (disp_hit)
      nxt = DISP;
    else if (host_valid && host_ready) begin
`ifdef VGA_FB_ARB_HOST_READ_EN
      nxt = host_we ? HOST_WR : HOST_RD;
`else
      nxt = HOST_WR;
`endif
    end
  end

  // The grant register doubles as the first owner-tag stage; tag_q is the second.
  always_comb begin
    tag_now = TAG_NONE;
    case (state)
      DISP:    tag_now = TAG_DISP;
`ifdef VGA_FB_ARB_HOST_READ_EN
      HOST_RD: tag_now = TAG_HOST;
`endif
      default: tag_now = TAG_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      tag_q           <= TAG_NONE;
      mem_addr        <= '0;
      mem_we          <= 1'b0;
      mem_wdata       <= '0;
      disp_data       <= '0;
      disp_data_valid <= 1'b0;
      disp_oob        <= 1'b0;
      host_wait_cnt   <= '0;
`ifdef VGA_FB_ARB_HOST_READ_EN
      host_rdata      <= '0;
      host_rvalid     <= 1'b0;
`endif
    end else begin
      state  <= nxt;
      mem_we <= (nxt == HOST_WR);
      case (nxt)
        DISP:    mem_addr <= disp_addr;
        HOST_WR: begin
          mem_addr  <= host_addr;
          mem_wdata <= host_wdata;
        end
`ifdef VGA_FB_ARB_HOST_READ_EN
        HOST_RD: mem_addr <= host_addr;
`endif
        default: ;
      endcase

      tag_q           <= tag_now;
      disp_data_valid <= (tag_q == TAG_DISP);
      if (tag_q == TAG_DISP)
        disp_data <= mem_rdata;
`ifdef VGA_FB_ARB_HOST_READ_EN
      host_rvalid <= (tag_q == TAG_HOST);
      if (tag_q == TAG_HOST)
        host_rdata <= mem_rdata;
`endif

      if (disp_req && !in_range)
        disp_oob <= 1'b1;
      if (host_valid && !host_ready && host_wait_cnt != 16'hFFFF)
        host_wait_cnt <= host_wait_cnt + 16'd1;
    end
  end

`ifndef VGA_FB_ARB_HOST_READ_EN
  assign host_rdata  = '0;
  assign host_rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter with a behavioural synchronous SRAM.
module tb_vga_fb_arbiter;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              disp_req = 1'b0;
  logic [9:0]        disp_x = '0, disp_y = '0;
  logic [DATA_W-1:0] disp_data;
  logic              disp_data_valid;
  logic              host_valid = 1'b0, host_ready, host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0, host_rdata;
  logic              host_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              disp_oob;
  logic [15:0]       host_wait_cnt;

  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .disp_data(disp_data), .disp_data_valid(disp_data_valid),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .disp_oob(disp_oob),
    .host_wait_cnt(host_wait_cnt)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  typedef struct packed {
    logic              is_host;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ret_check(input logic is_host, input logic [DATA_W-1:0] d);
    exp_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_return: host=%0d data=0x%0h, expected no return", is_host, d);
    end else begin
      e = q.pop_front();
      chk("ret_owner", 32'(is_host), 32'(e.is_host));
      chk("ret_data", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: every return pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (disp_data_valid) ret_check(1'b0, disp_data);
    if (host_rvalid)     ret_check(1'b1, host_rdata);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sram[1283]   <= 8'h3C;
    sram[307199] <= 8'h77;
    for (int i = 0; i < 640; i++) sram[6400 + i] <= 8'(i) ^ 8'h5A;

    // Reset with a pending host request
    host_valid = 1'b1; host_we = 1'b1;
    #1;
    chk("rst_host_ready", 32'(host_ready), 0);
    tick;
    chk("rst_host_ready2", 32'(host_ready), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_disp_data", 32'(disp_data), 0);
    chk("rst_disp_valid", 32'(disp_data_valid), 0);
    chk("rst_host_rdata", 32'(host_rdata), 0);
    chk("rst_host_rvalid", 32'(host_rvalid), 0);
    chk("rst_oob", 32'(disp_oob), 0);
    chk("rst_wait_cnt", 32'(host_wait_cnt), 0);
    reset = 1'b0; host_valid = 1'b0;
    tick;

    // Host write 0xA5 to 0x5 in blanking
    host_valid = 1'b1; host_we = 1'b1; host_addr = 19'h5; host_wdata = 8'hA5;
    #1;
    chk("wr_host_ready", 32'(host_ready), 1);
    tick;
    host_valid = 1'b0;
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 5);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
    tick;
    chk("wr_mem_we_off", 32'(mem_we), 0);

`ifdef VGA_FB_ARB_HOST_READ_EN
    // Host read back
    host_valid = 1'b1; host_we = 1'b0; host_addr = 19'h5;
    tick;
    host_valid = 1'b0;
    q.push_back('{is_host: 1'b1, data: 8'hA5});
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("rd_mem_addr", 32'(mem_addr), 5);
    tick; tick;
    chk("rd_rvalid", 32'(host_rvalid), 1);
    chk("rd_rdata", 32'(host_rdata), 32'hA5);
    tick;
    chk("rd_rvalid_pulse", 32'(host_rvalid), 0);
`else
    // Without host reads, host_we=0 still produces a write
    host_valid = 1'b1; host_we = 1'b0; host_addr = 19'h6; host_wdata = 8'h5A;
    tick;
    host_valid = 1'b0;
    chk("nord_mem_we", 32'(mem_we), 1);
    chk("nord_mem_addr", 32'(mem_addr), 6);
    tick; tick; tick;
    chk("nord_rvalid", 32'(host_rvalid), 0);
`endif

    // Display fetch x=3 y=2 -> 1283
    disp_req = 1'b1; disp_x = 10'd3; disp_y = 10'd2;
    tick;
    disp_req = 1'b0;
    q.push_back('{is_host: 1'b0, data: 8'h3C});
    chk("disp_mem_addr", 32'(mem_addr), 1283);
    chk("disp_mem_we", 32'(mem_we), 0);
    tick; tick;
    chk("disp_valid_k3", 32'(disp_data_valid), 1);
    chk("disp_data_k3", 32'(disp_data), 32'h3C);
    tick;
    chk("disp_valid_pulse", 32'(disp_data_valid), 0);

    // Back-to-back fetches: host-written word, then the last pixel of the frame
    disp_req = 1'b1; disp_x = 10'd5; disp_y = 10'd0;
    tick;
    q.push_back('{is_host: 1'b0, data: 8'hA5});
    chk("b2b_addr0", 32'(mem_addr), 5);
    disp_x = 10'd639; disp_y = 10'd479;
    tick;
    disp_req = 1'b0;
    q.push_back('{is_host: 1'b0, data: 8'h77});
    chk("b2b_addr1", 32'(mem_addr), 307199);
    repeat (4) tick;

    // Contention: full active line with host write pending
    host_valid = 1'b1; host_we = 1'b1; host_addr = 19'h100; host_wdata = 8'h11;
    for (int i = 0; i < 640; i++) begin
      disp_req = 1'b1; disp_x = 10'(i); disp_y = 10'd10;
      #1;
      chk("cont_host_ready", 32'(host_ready), 0);
      tick;
      q.push_back('{is_host: 1'b0, data: 8'(i) ^ 8'h5A});
    end
    disp_req = 1'b0;
    #1;
    chk("cont_wait_cnt", 32'(host_wait_cnt), 640);
    chk("cont_ready_blank", 32'(host_ready), 1);
    tick;
    host_valid = 1'b0;
    chk("cont_mem_we", 32'(mem_we), 1);
    chk("cont_mem_addr", 32'(mem_addr), 32'h100);
    chk("cont_wait_hold", 32'(host_wait_cnt), 640);
    repeat (4) tick;

    // Out of range request
    disp_req = 1'b1; disp_x = 10'd640; disp_y = 10'd0;
    tick;
    disp_req = 1'b0;
    chk("oob_flag", 32'(disp_oob), 1);
    chk("oob_mem_we", 32'(mem_we), 0);
    chk("oob_mem_addr", 32'(mem_addr), 32'h100);
    repeat (3) tick;
    chk("oob_no_valid", 32'(disp_data_valid), 0);
    chk("oob_sticky", 32'(disp_oob), 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("oob_cleared", 32'(disp_oob), 0);
    chk("oob_wait_cleared", 32'(host_wait_cnt), 0);

    // Reset one cycle after a display fetch is accepted
    disp_req = 1'b1; disp_x = 10'd3; disp_y = 10'd2;
    tick;
    disp_req = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rstmid_disp_valid", 32'(disp_data_valid), 0);
    end

`ifdef VGA_FB_ARB_HOST_READ_EN
    // Reset one cycle after a host read is accepted
    host_valid = 1'b1; host_we = 1'b0; host_addr = 19'h5;
    tick;
    host_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rstmid_host_rvalid", 32'(host_rvalid), 0);
    end
`endif

    repeat (4) tick;
    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
